// File: rtl/ram_if_pkg.sv
// Shared defaults and FSM state encoding for the RAM BIST initiator.
package ram_if_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam logic [7:0]  DEF_SEED   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        DONE = 3'd5
    } bist_state_e;

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Single-port RAM bus: the BIST controller is master, the RAM is slave.
interface ram_bist_ctrl_if #(
    parameter int unsigned ADDR_W = ram_if_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = ram_if_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic [DATA_W-1:0] data_out;

    modport master (output address, output data_in, output wr, input data_out);
    modport slave  (input address, input data_in, input wr, output data_out);
endinterface

// File: rtl/bist_rd_pipe.sv
// RD_LAT-deep delay line aligning {valid, expected, addr} with RAM read data.
module bist_rd_pipe #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] exp_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] exp_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int unsigned W = 1 + DATA_W + ADDR_W;

    logic [W-1:0] in_c;
    logic [W-1:0] out_c;

    assign in_c = {valid_i, exp_i, addr_i};

    if (RD_LAT == 0) begin : g_pass
        assign out_c = in_c;
    end else begin : g_dly
        logic [W-1:0] stage_q [RD_LAT];

        // Shift the read context one stage per clock; reset flushes all stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(RD_LAT); i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= in_c;
                for (int i = 1; i < int'(RD_LAT); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign out_c = stage_q[RD_LAT-1];
    end

    assign {valid_o, exp_o, addr_o} = out_c;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Two-pass write/read-compare self-test initiator for a single-port RAM.
module ram_bist_ctrl
    import ram_if_pkg::*;
#(
    parameter int unsigned       ADDR_W = DEF_ADDR_W,
    parameter int unsigned       DATA_W = DEF_DATA_W,
    parameter int unsigned       DEPTH  = 256,
    parameter int unsigned       RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    ram_bist_ctrl_if.master   ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_CNT   = 2'(RD_LAT);

    bist_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [7:0]        err_q;
    logic              rd_issue_q;
    logic [1:0]        drain_q;

    logic              rd_state_c;
    logic              rd_valid_c;
    logic [DATA_W-1:0] rd_exp_c;
    logic              pv_c;
    logic [DATA_W-1:0] pexp_c;
    logic [ADDR_W-1:0] paddr_c;
    logic              mism_c;
    logic [7:0]        err_nxt_c;
    logic              pass_end_c;

    // Test pattern: address XOR seed, inverted on the second pass.
    function automatic logic [DATA_W-1:0] pat_f(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ SEED;
        return inv ? ~p : p;
    endfunction

    // Read issue context, compare result and end-of-read-pass detection.
    always_comb begin
        rd_state_c = (state_q == RD0) || (state_q == RD1);
        rd_valid_c = rd_state_c && rd_issue_q;
        rd_exp_c   = pat_f(addr_q, state_q == RD1);
        mism_c     = pv_c && (pexp_c != ram.data_out);
        err_nxt_c  = err_q;
        if (mism_c && (err_q != 8'hFF)) err_nxt_c = err_q + 8'd1;
        pass_end_c = rd_state_c &&
                     ((rd_issue_q && (addr_q == LAST_ADDR) && (RD_LAT == 0)) ||
                      (!rd_issue_q && (drain_q == LAT_CNT)));
    end

    bist_rd_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_valid_c),
        .exp_i   (rd_exp_c),
        .addr_i  (addr_q),
        .valid_o (pv_c),
        .exp_o   (pexp_c),
        .addr_o  (paddr_c)
    );

    // Sequencer FSM with registered RAM bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            err_q       <= '0;
            rd_issue_q  <= 1'b0;
            drain_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (mism_c) begin
                err_q <= err_nxt_c;
                if (err_q == 8'd0) fail_addr_q <= paddr_c;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= WR0;
                        err_q       <= '0;
                        fail_addr_q <= '0;
                        pass_q      <= 1'b0;
                        addr_q      <= '0;
                        wdata_q     <= pat_f('0, 1'b0);
                        wr_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        rd_issue_q  <= 1'b0;
                        drain_q     <= '0;
                    end
                end
                WR0, WR1: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q    <= (state_q == WR0) ? RD0 : RD1;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        wr_q       <= 1'b0;
                        rd_issue_q <= 1'b1;
                        drain_q    <= '0;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        wdata_q <= pat_f(addr_q + ADDR_W'(1), state_q == WR1);
                    end
                end
                RD0, RD1: begin
                    if (pass_end_c) begin
                        rd_issue_q <= 1'b0;
                        drain_q    <= '0;
                        if (state_q == RD0) begin
                            state_q <= WR1;
                            addr_q  <= '0;
                            wdata_q <= pat_f('0, 1'b1);
                            wr_q    <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_nxt_c == 8'd0);
                        end
                    end else if (rd_issue_q) begin
                        if (addr_q == LAST_ADDR) begin
                            rd_issue_q <= 1'b0;
                            drain_q    <= 2'd1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram.address = addr_q;
    assign ram.data_in = wdata_q;
    assign ram.wr      = wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_addr   = fail_addr_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: three configurations, behavioural RAMs with fault injection.
module tb_ram_bist_ctrl;

    typedef struct {
        int         done_n;
        bit         pass;
        logic [7:0] err;
        logic [7:0] fa;
    } exp_t;

    logic clk;
    logic rst;
    logic start_r;
    int   sel;
    int   fault_mode;
    int   n_assert;
    int   n_fail;
    exp_t sb_q[$];

    ram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_m ();
    ram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_s0 ();
    ram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_s2 ();

    logic       busy_m, done_m, pass_m, busy_s0, done_s0, pass_s0, busy_s2, done_s2, pass_s2;
    logic [7:0] fa_m, err_m, fa_s0, err_s0, fa_s2, err_s2;
    logic       start_m, start_s0, start_s2;

    assign start_m  = start_r && (sel == 0);
    assign start_s0 = start_r && (sel == 1);
    assign start_s2 = start_r && (sel == 2);

    ram_bist_ctrl #(.DEPTH(256), .RD_LAT(1)) u_dut_m (
        .clk(clk), .rst(rst), .start(start_m), .ram(bus_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .fail_addr(fa_m), .err_count(err_m));
    ram_bist_ctrl #(.DEPTH(4), .RD_LAT(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start_s0), .ram(bus_s0),
        .busy(busy_s0), .done(done_s0), .pass(pass_s0), .fail_addr(fa_s0), .err_count(err_s0));
    ram_bist_ctrl #(.DEPTH(4), .RD_LAT(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start_s2), .ram(bus_s2),
        .busy(busy_s2), .done(done_s2), .pass(pass_s2), .fail_addr(fa_s2), .err_count(err_s2));

    // Main RAM, latency 1: mode 1 = bit0 stuck-at-0 at addr 3, mode 2 = reads of 5/9 inverted.
    logic [7:0] mem_m [256];
    logic [7:0] rd_m_q, ra_m_q;
    always @(posedge clk) begin
        if (bus_m.wr)
            mem_m[bus_m.address] <= (fault_mode == 1 && bus_m.address == 8'd3) ?
                                    (bus_m.data_in & 8'hFE) : bus_m.data_in;
        rd_m_q <= mem_m[bus_m.address];
        ra_m_q <= bus_m.address;
    end
    assign bus_m.data_out = (fault_mode == 2 && (ra_m_q == 8'd5 || ra_m_q == 8'd9)) ? ~rd_m_q : rd_m_q;

    // Small RAM, latency 0.
    logic [7:0] mem_s0 [4];
    always @(posedge clk) if (bus_s0.wr) mem_s0[bus_s0.address[1:0]] <= bus_s0.data_in;
    assign bus_s0.data_out = mem_s0[bus_s0.address[1:0]];

    // Small RAM, latency 2.
    logic [7:0] mem_s2 [4];
    logic [7:0] rd_s2_q1, rd_s2_q2;
    always @(posedge clk) begin
        if (bus_s2.wr) mem_s2[bus_s2.address[1:0]] <= bus_s2.data_in;
        rd_s2_q1 <= mem_s2[bus_s2.address[1:0]];
        rd_s2_q2 <= rd_s2_q1;
    end
    assign bus_s2.data_out = rd_s2_q2;

    // Observation mux for the configuration under test.
    logic       o_busy, o_done, o_pass, o_wr;
    logic [7:0] o_addr, o_din, o_fa, o_err;
    always_comb begin
        o_busy = busy_m; o_done = done_m; o_pass = pass_m; o_fa = fa_m; o_err = err_m;
        o_wr = bus_m.wr; o_addr = bus_m.address; o_din = bus_m.data_in;
        if (sel == 1) begin
            o_busy = busy_s0; o_done = done_s0; o_pass = pass_s0; o_fa = fa_s0; o_err = err_s0;
            o_wr = bus_s0.wr; o_addr = bus_s0.address; o_din = bus_s0.data_in;
        end else if (sel == 2) begin
            o_busy = busy_s2; o_done = done_s2; o_pass = pass_s2; o_fa = fa_s2; o_err = err_s2;
            o_wr = bus_s2.wr; o_addr = bus_s2.address; o_din = bus_s2.data_in;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pat(input int a, input bit ph);
        logic [7:0] v;
        v = 8'(a) ^ 8'hA5;
        return ph ? ~v : v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, o_wr, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_pass"}, o_pass, 0);
        check({tag, "_addr"}, o_addr, 0);
        check({tag, "_din"}, o_din, 0);
        check({tag, "_fa"}, o_fa, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    // One complete test: pulse start, follow the write stream, pop the scoreboard on done.
    task automatic run_test(input int s, input int depth, input int lat, input bit e_pass,
                            input logic [7:0] e_err, input logic [7:0] e_fa, input int restart_n);
        int   n;
        int   wcount;
        int   done_cnt;
        bit   seen;
        exp_t e;
        sel = s;
        sb_q.push_back('{1 + 2 * (2 * depth + lat), e_pass, e_err, e_fa});
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r  = 1'b0;
        n        = 1;
        wcount   = 0;
        done_cnt = 0;
        seen     = 0;
        check("first_wr", o_wr, 1);
        check("first_busy", o_busy, 1);
        while (!seen && n <= 2 * (2 * depth + lat) + 50) begin
            if (o_wr) begin
                check("wr_addr", o_addr, wcount % depth);
                check("wr_data", o_din, exp_pat(wcount % depth, wcount >= depth));
                wcount++;
            end
            if (o_done) begin
                seen = 1;
                done_cnt++;
                e = sb_q.pop_front();
                check("done_cycle", n, e.done_n);
                check("done_busy", o_busy, 0);
                check("pass", o_pass, e.pass);
                check("err_count", o_err, e.err);
                check("fail_addr", o_fa, e.fa);
            end else begin
                start_r = (n + 1 == restart_n);
                @(posedge clk); #1;
                start_r = 1'b0;
                n++;
            end
        end
        check("done_seen", seen, 1);
        check("write_count", wcount, 2 * depth);
        @(posedge clk); #1;
        if (o_done) done_cnt++;
        check("done_single", done_cnt, 1);
        check("idle_busy", o_busy, 0);
        check("pass_held", o_pass, e_pass);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        sel        = 0;
        fault_mode = 0;
        start_r    = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Fault-free, then stuck-at bit, then corrupted reads; back-to-back starts.
        run_test(0, 256, 1, 1'b1, 8'd0, 8'd0, 0);
        fault_mode = 1;
        run_test(0, 256, 1, 1'b0, 8'd1, 8'd3, 0);
        fault_mode = 2;
        run_test(0, 256, 1, 1'b0, 8'd4, 8'd5, 0);

        // Start pulse during WR1 must be ignored.
        fault_mode = 0;
        run_test(0, 256, 1, 1'b1, 8'd0, 8'd0, 1 + 256 + 257 + 10);

        // Reset midway through RD0 with errors already counted.
        fault_mode = 2;
        sel        = 0;
        start_r    = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (356) @(posedge clk);
        #1;
        check("pre_rst_err", o_err, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("mid_rst");
        fault_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        run_test(0, 256, 1, 1'b1, 8'd0, 8'd0, 0);

        // Small arrays with zero and two-cycle read latency.
        run_test(1, 4, 0, 1'b1, 8'd0, 8'd0, 0);
        run_test(2, 4, 2, 1'b1, 8'd0, 8'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
